// File: rtl/pinmux_pkg.sv
// Shared constants for the Wishbone pad multiplexer: register word offsets,
// select-field geometry and the GPIO function code.
package pinmux_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] FN_GPIO = 4'd0;

  // Word offsets (byte address >> 2)
  localparam logic [5:0] OFS_CTRL        = 6'h00;
  localparam logic [5:0] OFS_SEL0        = 6'h04;
  localparam logic [5:0] OFS_IRQ_EN_LO   = 6'h10;
  localparam logic [5:0] OFS_IRQ_EN_HI   = 6'h11;
  localparam logic [5:0] OFS_IRQ_STAT_LO = 6'h12;
  localparam logic [5:0] OFS_IRQ_STAT_HI = 6'h13;
  localparam logic [5:0] OFS_PAD_IN_LO   = 6'h14;
  localparam logic [5:0] OFS_PAD_IN_HI   = 6'h15;

  function automatic int num_sel_regs(input int num_pads);
    return (num_pads + 7) / 8;
  endfunction

endpackage

// File: rtl/io_pinmux_wb_if.sv
// Wishbone classic slave bus used to program the pad multiplexer.
// Handshake: a request is stb&cyc while ack is low; ack pulses for exactly one
// cycle, one cycle after the request, carrying registered read data.
interface io_pinmux_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/pinmux_pad_filter.sv
// One pad input path: multi-flop synchroniser followed by a saturating
// debounce counter. A threshold of zero bypasses the debounce entirely.
module pinmux_pad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_i,
  input  logic [DEB_W-1:0] thresh_i,
  output logic             filt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync_v;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    sync_v = sync_q[SYNC_STAGES-1];
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (thresh_i == '0) begin
      filt_d = sync_v;
      cnt_d  = '0;
    end else if (sync_v == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh_i - DEB_W'(1)) begin
      // This cycle is the thresh-th consecutive disagreement
      filt_d = ~filt_q;
      cnt_d  = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DEB_W'(1);
    end
    filt_o = (thresh_i == '0) ? sync_v : filt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/io_pinmux_wb.sv
// Wishbone-programmable pad multiplexer: register file, per-pad function
// select with lock, filtered inputs to GPIO/peripherals, rising-edge IRQs.
module io_pinmux_wb
  import pinmux_pkg::*;
#(
  parameter int NUM_PADS    = 38,
  parameter int NUM_FUNCS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  io_pinmux_wb_if.slave                     wb,
  input  logic [NUM_PADS-1:0]               io_in,
  output logic [NUM_PADS-1:0]               io_out,
  output logic [NUM_PADS-1:0]               io_oeb,
  input  logic [NUM_PADS-1:0]               gpio_o,
  input  logic [NUM_PADS-1:0]               gpio_oe,
  output logic [NUM_PADS-1:0]               gpio_i,
  input  logic [(NUM_FUNCS-1)*NUM_PADS-1:0] fn_o,
  input  logic [(NUM_FUNCS-1)*NUM_PADS-1:0] fn_oe,
  output logic [(NUM_FUNCS-1)*NUM_PADS-1:0] fn_i,
  output logic                              irq_o
);

  localparam int NUM_SEL_REGS = num_sel_regs(NUM_PADS);

  logic                           lock_q, lock_d;
  logic [7:0]                     deb_q, deb_d;
  logic [NUM_PADS-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [NUM_PADS-1:0]            en_q, en_d, stat_q, stat_d, prev_q, clr, filt;
  logic                           ack_q, ack_d, irq_q, irq_d;
  logic [31:0]                    dat_q, dat_d, rdata;
  logic                           req, wr, sel_win;
  logic [5:0]                     word;
  logic                           unused_ok;

  assign unused_ok = &{1'b0, wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0]};

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pinmux_pad_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W)) u_filt (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .pad_i    (io_in[p]),
      .thresh_i (DEB_W'(deb_q)),
      .filt_o   (filt[p])
    );
  end

  // Register file: writes commit on the same edge that raises ack
  always_comb begin
    req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    wr      = req & wb.wbs_we_i;
    word    = wb.wbs_adr_i[7:2];
    sel_win = (word >= OFS_SEL0) && (word < OFS_SEL0 + 6'(NUM_SEL_REGS));
    lock_d  = lock_q;
    deb_d   = deb_q;
    sel_d   = sel_q;
    en_d    = en_q;
    clr     = '0;
    rdata   = '0;
    if (word == OFS_CTRL) begin
      rdata = {16'h0, deb_q, 7'h0, lock_q};
      if (wr && wb.wbs_sel_i[0] && wb.wbs_dat_i[0]) lock_d = 1'b1;
      if (wr && wb.wbs_sel_i[1] && !lock_q)         deb_d  = wb.wbs_dat_i[15:8];
    end
    for (int p = 0; p < NUM_PADS; p++) begin
      if (sel_win && word == OFS_SEL0 + 6'(p / 8)) begin
        rdata[4*(p%8) +: SEL_W] = sel_q[p];
        if (wr && !lock_q && wb.wbs_sel_i[(p%8)/2])
          sel_d[p] = wb.wbs_dat_i[4*(p%8) +: SEL_W];
      end
      if (word == (p < 32 ? OFS_IRQ_EN_LO : OFS_IRQ_EN_HI)) begin
        rdata[p%32] = en_q[p];
        if (wr && wb.wbs_sel_i[(p%32)/8]) en_d[p] = wb.wbs_dat_i[p%32];
      end
      if (word == (p < 32 ? OFS_IRQ_STAT_LO : OFS_IRQ_STAT_HI)) begin
        rdata[p%32] = stat_q[p];
        if (wr && wb.wbs_sel_i[(p%32)/8]) clr[p] = wb.wbs_dat_i[p%32];
      end
      if (word == (p < 32 ? OFS_PAD_IN_LO : OFS_PAD_IN_HI))
        rdata[p%32] = filt[p];
    end
    // A new edge overrides a simultaneous W1C
    stat_d = (stat_q & ~clr) | (filt & ~prev_q & en_q);
    irq_d  = |(stat_q & en_q);
    ack_d  = req;
    dat_d  = (req && !wb.wbs_we_i) ? rdata : 32'h0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lock_q <= 1'b0;
      deb_q  <= '0;
      sel_q  <= {NUM_PADS{FN_GPIO}};
      en_q   <= '0;
      stat_q <= '0;
      prev_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      lock_q <= lock_d;
      deb_q  <= deb_d;
      sel_q  <= sel_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      prev_q <= filt;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end
  end

  // Select codes outside 1..NUM_FUNCS-1 match no function and fall back to GPIO
  always_comb begin
    io_out = gpio_o;
    io_oeb = ~gpio_oe;
    fn_i   = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int f = 1; f < NUM_FUNCS; f++) begin
        if (sel_q[p] == SEL_W'(f)) begin
          io_out[p]                   = fn_o[(f-1)*NUM_PADS + p];
          io_oeb[p]                   = ~fn_oe[(f-1)*NUM_PADS + p];
          fn_i[(f-1)*NUM_PADS + p]    = filt[p];
        end
      end
    end
  end

  assign gpio_i       = filt;
  assign irq_o        = irq_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

endmodule
